i2c_passthru_bus_arbiter: RTL and testbench
===========================================

# i2c_passthru_bus_arbiter

- Shares the single downstream I2C bus between two upstream passthru ports.
- Consumes the idle/timeout/stuck indications of the downstream bus monitor-recover block.
- Grants the bus to one requester only while the bus is idle, holds the grant until the transaction ends, and enforces a bus-free gap before the next grant.
- Revokes all grants and hands the bus to the recover block when it is stuck.

## Interface
Parameters:
- F_REF_T_BUF, 38: i_f_ref ticks of bus-free gap between a release and the next grant.
- F_REF_T_CLAIM, 400: i_f_ref ticks a grantee has to issue START before its grant is withdrawn.
- WIDTH_F_REF_T_BUF, 6: counter width, ceil(log2(F_REF_T_BUF+1)).
- WIDTH_F_REF_T_CLAIM, 9: counter width, ceil(log2(F_REF_T_CLAIM+1)).

Ports:
- i_clk  in  1  sole clock.
- i_rstn  in  1  reset; asynchronous, active-low.
- i_f_ref  in  1  slow reference; rising edge (registered prev vs current) = one tick.
- i_req  in  2  level request per port; bit0 = port 0.
- i_idle  in  1  downstream bus idle (level).
- i_idle_timeout  in  1  single-cycle pulse: idle reached via high timeout.
- i_stuck  in  1  downstream bus stuck, recovery running.
- o_gnt  out  2  one-hot-or-zero grant, registered.
- o_recover  out  1  recover block owns bus drivers, registered.
- o_busy  out  1  any grant or recovery in progress, registered.
- o_last  out  1  index of last port granted.
- o_timeout_cnt  out  8  saturating count of i_idle_timeout pulses.

## Operation
- States: ST_IDLE, ST_CLAIM, ST_ACTIVE, ST_GUARD, ST_STUCK.
- ST_IDLE:
  - If i_stuck, go to ST_STUCK.
  - Else if i_idle and any i_req, pick a winner, set o_gnt[winner], o_last<=winner, load claim timer, go to ST_CLAIM.
- ST_CLAIM:
  - If i_stuck, go to ST_STUCK.
  - Else if !i_idle (START seen), go to ST_ACTIVE.
  - Else if i_req[winner]==0 or claim timer reaches 0, clear o_gnt, load buf timer, go to ST_GUARD.
- ST_ACTIVE:
  - If i_stuck, go to ST_STUCK.
  - Else if i_idle (STOP or timeout), clear o_gnt, load buf timer, go to ST_GUARD.
  - i_req dropping here is ignored; the transaction must finish.
- ST_GUARD:
  - If i_stuck, go to ST_STUCK.
  - Else if !i_idle (foreign START), reload buf timer and stay.
  - Else if buf timer reaches 0, go to ST_IDLE.
- ST_STUCK:
  - o_gnt=0 and o_recover=1.
  - When i_stuck==0 and i_idle==1, clear o_recover, load buf timer, go to ST_GUARD.
- Timers decrement only on an i_f_ref tick, stop at 0, and are reloaded on state entry.
- o_timeout_cnt increments on each i_idle_timeout pulse in any state and saturates at 8'hFF.
- o_busy = (state != ST_IDLE) && (state != ST_GUARD).
- Illegal state encoding goes to ST_STUCK on the next cycle, with o_gnt cleared.

## Timing
- Reset values: o_gnt=2'b00, o_recover=0, o_busy=0, o_last=1 (port 0 wins first under round-robin), o_timeout_cnt=0, state=ST_IDLE, timers at their reload values, prev i_f_ref=0.
- Grant latency: o_gnt is asserted on the clock edge after the cycle in which i_idle&&i_req is sampled in ST_IDLE.
- Release latency: o_gnt is cleared on the edge after i_idle or i_stuck is sampled.
- Gap: no two grants are closer than F_REF_T_BUF ticks of continuous idle.
- Stuck has priority over every other transition, including a same-cycle i_idle or claim expiry.
- Simultaneous i_req=2'b11 in ST_IDLE is resolved by the arbitration mode (see Configuration).
- A tick coinciding with a timer reload is not counted.
- Reset asserted mid-transaction clears o_gnt asynchronously; the arbiter restarts in ST_IDLE.

## Configuration
- I2C_PASSTHRU_ARB_RR_EN defined: round-robin; on a tie the winner is ~o_last.
- I2C_PASSTHRU_ARB_RR_EN undefined: fixed priority; port 0 always wins a tie. o_last is still updated.

## Test plan
- Reset, i_idle=1, i_req=2'b01 → o_gnt=2'b01 one cycle later; drive i_idle=0 then 1 → o_gnt=0, then 38 ticks before any new grant.
- i_req=2'b11 held across three transactions → RR build: grants 01,10,01; fixed build: 01,01,01.
- Grant port 1 with no START for 400 ticks → o_gnt=0 after the 400th tick, state ST_GUARD; timer behaviour matches the ST_CLAIM rules.
- Pulse i_stuck during ST_ACTIVE with i_idle=1 in the same cycle → o_gnt=0 and o_recover=1 next cycle; release i_stuck with i_idle=1 → o_recover=0, then a 38-tick gap.
- 300 i_idle_timeout pulses → o_timeout_cnt=255 and holds.
- Assert i_rstn=0 asynchronously mid ST_ACTIVE → o_gnt=0 immediately, without a clock edge.

Source files
------------

// File: rtl/i2c_passthru_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_passthru_bus_arbiter
//
// Shares one downstream I2C bus between two upstream passthru ports. A port
// is granted the bus only while the bus is idle. The grant is held until the
// transaction ends. A bus-free gap, counted in i_f_ref ticks, must pass
// before the next grant. If the bus monitor reports the bus stuck, all
// grants are revoked and the recover block is given the bus drivers.
//
// Build option:
//   I2C_PASSTHRU_ARB_RR_EN  defined   -> round-robin tie-break (~o_last wins)
//                           undefined -> fixed priority (port 0 wins ties)
//
// Ports:
//   i_clk           sole clock
//   i_rstn          asynchronous active-low reset
//   i_f_ref         slow reference; each rising edge is one timer tick
//   i_req[1:0]      level request per upstream port (bit0 = port 0)
//   i_idle          downstream bus idle level
//   i_idle_timeout  single-cycle pulse: idle was reached via high timeout
//   i_stuck         downstream bus stuck, recovery running
//   o_gnt[1:0]      one-hot-or-zero grant
//   o_recover       recover block owns the bus drivers
//   o_busy          a grant or a recovery is in progress
//   o_last          index of the last port granted
//   o_timeout_cnt   saturating count of i_idle_timeout pulses
// ---------------------------------------------------------------------------
module i2c_passthru_bus_arbiter #(
    parameter int F_REF_T_BUF         = 38,
    parameter int F_REF_T_CLAIM       = 400,
    parameter int WIDTH_F_REF_T_BUF   = 6,
    parameter int WIDTH_F_REF_T_CLAIM = 9
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_f_ref,
    input  logic [1:0] i_req,
    input  logic       i_idle,
    input  logic       i_idle_timeout,
    input  logic       i_stuck,
    output logic [1:0] o_gnt,
    output logic       o_recover,
    output logic       o_busy,
    output logic       o_last,
    output logic [7:0] o_timeout_cnt
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLAIM  = 3'd1;
    localparam logic [2:0] ST_ACTIVE = 3'd2;
    localparam logic [2:0] ST_GUARD  = 3'd3;
    localparam logic [2:0] ST_STUCK  = 3'd4;

    localparam logic [WIDTH_F_REF_T_BUF-1:0]   BUF_RELOAD   = WIDTH_F_REF_T_BUF'(F_REF_T_BUF);
    localparam logic [WIDTH_F_REF_T_CLAIM-1:0] CLAIM_RELOAD = WIDTH_F_REF_T_CLAIM'(F_REF_T_CLAIM);

    logic [2:0]                     state_q, state_d;
    logic [1:0]                     gnt_q, gnt_d;
    logic                           last_q, last_d;
    logic                           recover_q, recover_d;
    logic                           busy_q, busy_d;
    logic [7:0]                     tcnt_q, tcnt_d;
    logic [WIDTH_F_REF_T_BUF-1:0]   buf_q, buf_d, buf_dec;
    logic [WIDTH_F_REF_T_CLAIM-1:0] claim_q, claim_d, claim_dec;
    logic                           f_ref_prev_q;
    logic                           tick;
    logic                           win;

    assign tick = i_f_ref & ~f_ref_prev_q;

    // Timers count down on ticks only and park at zero.
    assign buf_dec   = (tick && buf_q != '0)   ? buf_q - WIDTH_F_REF_T_BUF'(1)     : buf_q;
    assign claim_dec = (tick && claim_q != '0) ? claim_q - WIDTH_F_REF_T_CLAIM'(1) : claim_q;

    // Winner for the current request pattern; only a tie depends on the mode.
    always_comb begin
        win = 1'b0;
        if (i_req == 2'b10) begin
            win = 1'b1;
        end else if (i_req == 2'b11) begin
`ifdef I2C_PASSTHRU_ARB_RR_EN
            win = ~last_q;
`else
            win = 1'b0;
`endif
        end
    end

    // Stuck is tested first in every state so it overrides same-cycle idle
    // or timer expiry. A timer reload simply overwrites the decremented
    // value, so a tick coinciding with a reload is dropped.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        buf_d   = buf_q;
        claim_d = claim_q;
        case (state_q)
            ST_IDLE: begin
                if (i_stuck) begin
                    state_d = ST_STUCK;
                    gnt_d   = 2'b00;
                end else if (i_idle && (i_req != 2'b00)) begin
                    gnt_d   = win ? 2'b10 : 2'b01;
                    last_d  = win;
                    claim_d = CLAIM_RELOAD;
                    state_d = ST_CLAIM;
                end
            end
            ST_CLAIM: begin
                claim_d = claim_dec;
                if (i_stuck) begin
                    state_d = ST_STUCK;
                    gnt_d   = 2'b00;
                end else if (!i_idle) begin
                    state_d = ST_ACTIVE;
                end else if (!i_req[last_q] || (claim_q == '0)) begin
                    gnt_d   = 2'b00;
                    buf_d   = BUF_RELOAD;
                    state_d = ST_GUARD;
                end
            end
            ST_ACTIVE: begin
                // A dropped request is ignored here: the transaction runs to STOP.
                if (i_stuck) begin
                    state_d = ST_STUCK;
                    gnt_d   = 2'b00;
                end else if (i_idle) begin
                    gnt_d   = 2'b00;
                    buf_d   = BUF_RELOAD;
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                buf_d = buf_dec;
                if (i_stuck) begin
                    state_d = ST_STUCK;
                end else if (!i_idle) begin
                    // Foreign START: the free-bus gap starts over.
                    buf_d = BUF_RELOAD;
                end else if (buf_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STUCK: begin
                gnt_d = 2'b00;
                if (!i_stuck && i_idle) begin
                    buf_d   = BUF_RELOAD;
                    state_d = ST_GUARD;
                end
            end
            default: begin
                state_d = ST_STUCK;
                gnt_d   = 2'b00;
            end
        endcase
    end

    assign recover_d = (state_d == ST_STUCK);
    assign busy_d    = (state_d != ST_IDLE) && (state_d != ST_GUARD);
    assign tcnt_d    = (i_idle_timeout && (tcnt_q != 8'hFF)) ? tcnt_q + 8'd1 : tcnt_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 2'b00;
            last_q       <= 1'b1;
            recover_q    <= 1'b0;
            busy_q       <= 1'b0;
            tcnt_q       <= 8'h00;
            buf_q        <= BUF_RELOAD;
            claim_q      <= CLAIM_RELOAD;
            f_ref_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            recover_q    <= recover_d;
            busy_q       <= busy_d;
            tcnt_q       <= tcnt_d;
            buf_q        <= buf_d;
            claim_q      <= claim_d;
            f_ref_prev_q <= i_f_ref;
        end
    end

    assign o_gnt         = gnt_q;
    assign o_recover     = recover_q;
    assign o_busy        = busy_q;
    assign o_last        = last_q;
    assign o_timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_i2c_passthru_bus_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for i2c_passthru_bus_arbiter.
// Expected values are pushed to a scoreboard queue as each directed step is
// driven and popped when the corresponding DUT output is sampled.
// ---------------------------------------------------------------------------
module tb_i2c_passthru_bus_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic       f_ref;
    logic [1:0] req;
    logic       idle;
    logic       idle_to;
    logic       stuck;
    logic [1:0] gnt;
    logic       recover;
    logic       busy;
    logic       last;
    logic [7:0] tcnt;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb_q[$];
    logic [1:0]  exp_tie[4];

    i2c_passthru_bus_arbiter dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_f_ref        (f_ref),
        .i_req          (req),
        .i_idle         (idle),
        .i_idle_timeout (idle_to),
        .i_stuck        (stuck),
        .o_gnt          (gnt),
        .o_recover      (recover),
        .o_busy         (busy),
        .o_last         (last),
        .o_timeout_cnt  (tcnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One i_f_ref rising edge; four clocks per tick.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            f_ref = 1'b1;
            step(2);
            f_ref = 1'b0;
            step(2);
        end
    endtask

    task automatic expect_val(input logic [31:0] v);
        sb_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty got=%0h", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            assert (obs === exp) else begin
                failures++;
                $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
            end
        end
    endtask

    initial begin
`ifdef I2C_PASSTHRU_ARB_RR_EN
        exp_tie[0] = 2'b01; exp_tie[1] = 2'b10; exp_tie[2] = 2'b01; exp_tie[3] = 2'b10;
`else
        exp_tie[0] = 2'b01; exp_tie[1] = 2'b01; exp_tie[2] = 2'b01; exp_tie[3] = 2'b01;
`endif
        rstn = 1'b0; f_ref = 1'b0; req = 2'b00; idle = 1'b1; idle_to = 1'b0; stuck = 1'b0;

        // Reset values
        step(2);
        expect_val(0); check("rst_gnt", 32'(gnt));
        expect_val(0); check("rst_recover", 32'(recover));
        expect_val(0); check("rst_busy", 32'(busy));
        expect_val(1); check("rst_last", 32'(last));
        expect_val(0); check("rst_tcnt", 32'(tcnt));
        rstn = 1'b1;
        step(1);

        // Basic grant, transaction, release and bus-free gap
        req = 2'b01; expect_val(32'b01); expect_val(1); expect_val(0);
        step(1);
        check("grant_p0", 32'(gnt)); check("grant_busy", 32'(busy)); check("grant_last", 32'(last));
        idle = 1'b0; expect_val(32'b01);
        step(1);
        check("active_gnt", 32'(gnt));
        req = 2'b00; expect_val(32'b01);
        step(2);
        check("active_req_drop", 32'(gnt));
        idle = 1'b1; expect_val(0); expect_val(0);
        step(1);
        check("stop_release", 32'(gnt)); check("guard_busy", 32'(busy));
        req = 2'b01; expect_val(0);
        ticks(37);
        check("gap_37", 32'(gnt));
        expect_val(32'b01);
        ticks(1);
        check("gap_38_grant", 32'(gnt));
        req = 2'b00; expect_val(0);
        step(1);
        check("claim_req_drop", 32'(gnt));
        ticks(38);

        // Tie held across transactions, restarting from reset state
        rstn = 1'b0; step(1); rstn = 1'b1; step(1);
        req = 2'b11;
        step(1);
        for (int k = 0; k < 3; k++) begin
            expect_val(32'(exp_tie[k]));
            check($sformatf("tie_grant_%0d", k), 32'(gnt));
            idle = 1'b0; step(1);
            idle = 1'b1; expect_val(0);
            step(1);
            check($sformatf("tie_release_%0d", k), 32'(gnt));
            ticks(38);
        end
        expect_val(32'(exp_tie[3]));
        check("tie_grant_3", 32'(gnt));
        req = 2'b00; expect_val(0);
        step(1);
        check("tie_final_release", 32'(gnt));
        ticks(38);

        // Claim window expiry for port 1
        req = 2'b10; expect_val(32'b10); expect_val(1);
        step(1);
        check("claim_p1", 32'(gnt)); check("claim_last", 32'(last));
        expect_val(32'b10);
        ticks(399);
        check("claim_399", 32'(gnt));
        expect_val(0); expect_val(0);
        ticks(1);
        check("claim_expired", 32'(gnt)); check("claim_exp_busy", 32'(busy));
        req = 2'b00;
        ticks(38);

        // Stuck during ACTIVE together with idle
        req = 2'b01; step(1);
        idle = 1'b0; step(1);
        idle = 1'b1; stuck = 1'b1;
        expect_val(0); expect_val(1); expect_val(1);
        step(1);
        check("stuck_gnt", 32'(gnt)); check("stuck_recover", 32'(recover)); check("stuck_busy", 32'(busy));
        expect_val(1);
        step(2);
        check("stuck_hold", 32'(recover));
        stuck = 1'b0; expect_val(0); expect_val(0); expect_val(0);
        step(1);
        check("unstuck_recover", 32'(recover)); check("unstuck_busy", 32'(busy)); check("unstuck_gnt", 32'(gnt));
        expect_val(0);
        ticks(37);
        check("stuck_gap_37", 32'(gnt));
        expect_val(32'b01);
        ticks(1);
        check("stuck_gap_38", 32'(gnt));
        req = 2'b00; step(1);
        ticks(38);

        // Timeout pulse counter saturation
        for (int i = 0; i < 300; i++) begin
            idle_to = 1'b1; step(1);
            idle_to = 1'b0; step(1);
            if (i == 99) begin
                expect_val(100);
                check("tcnt_100", 32'(tcnt));
            end
        end
        expect_val(255);
        check("tcnt_sat", 32'(tcnt));
        expect_val(255);
        step(3);
        check("tcnt_hold", 32'(tcnt));

        // Asynchronous reset in the middle of a transaction
        req = 2'b01; step(1);
        idle = 1'b0; expect_val(32'b01);
        step(1);
        check("pre_arst_gnt", 32'(gnt));
        #2;
        rstn = 1'b0;
        #1;
        expect_val(0); expect_val(0); expect_val(1);
        check("arst_gnt", 32'(gnt)); check("arst_tcnt", 32'(tcnt)); check("arst_last", 32'(last));
        req = 2'b00; idle = 1'b1;
        step(2);
        rstn = 1'b1;
        step(1);
        expect_val(0);
        check("post_arst_busy", 32'(busy));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
